// File: rtl/irq_dispatch12_pkg.sv
// Shared definitions for the 12-line interrupt dispatcher.
//   NUM_IRQ : number of request lines
//   ID_W    : width of an encoded line index
//   state_t : dispatcher FSM states
package irq_dispatch12_pkg;
    localparam int NUM_IRQ = 12;
    localparam int ID_W    = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;
endpackage

// File: rtl/irq_dispatch12_prio_enc12.sv
// Combinational fixed-priority encoder: bit 0 of eligible has the highest
// priority, bit 11 the lowest.
//   eligible : pending & ~mask request vector
//   idx      : index of the lowest-numbered set bit (0 when none set)
//   any      : at least one eligible bit set
module prio_enc12
    import irq_dispatch12_pkg::*;
(
    input  logic [0:NUM_IRQ-1] eligible,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    // Scan from the lowest priority upward so the last hit is the winner.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                idx = ID_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_dispatch12.sv
// Edge-triggered interrupt dispatcher with 12 prioritized request lines.
// Rising edges latch into pending; the highest-priority unmasked pending line
// is presented as a vector and held until acknowledged. A second edge on a
// line that is still pending sets its sticky overrun flag.
//   clk       : clock, rising-edge active
//   rst_n     : asynchronous active-low reset
//   irq_in    : request lines, bit 0 highest priority
//   mask      : 1 = line held back from dispatch (still latched)
//   vec_ack   : consumer accepts the presented vector
//   clr_ovr   : pulse clearing all overrun flags
//   vec_valid : a vector is presented
//   vec_id    : index of the presented line
//   pending   : latched, not-yet-serviced requests
//   ovr       : sticky overrun flags
module irq_dispatch12
    import irq_dispatch12_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [0:NUM_IRQ-1] irq_in,
    input  logic [0:NUM_IRQ-1] mask,
    input  logic               vec_ack,
    input  logic               clr_ovr,
    output logic               vec_valid,
    output logic [ID_W-1:0]    vec_id,
    output logic [0:NUM_IRQ-1] pending,
    output logic [0:NUM_IRQ-1] ovr
);

    state_t             state_reg;
    logic [0:NUM_IRQ-1] irq_prev_reg;
    logic [0:NUM_IRQ-1] rise;
    logic [0:NUM_IRQ-1] eligible;
    logic [0:NUM_IRQ-1] pending_next;
    logic [0:NUM_IRQ-1] ovr_next;
    logic [ID_W-1:0]    sel_idx;
    logic               sel_any;
    logic               ack_fire;

    // Acknowledge only means something while a vector is presented.
    assign ack_fire = (state_reg == ST_PRESENT) && vec_ack;
    assign eligible = pending & ~mask;

    prio_enc12 u_prio_enc12 (
        .eligible (eligible),
        .idx      (sel_idx),
        .any      (sel_any)
    );

    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
        logic ack_this;
        assign ack_this = ack_fire && (vec_id == ID_W'(gi));
        assign rise[gi] = irq_in[gi] & ~irq_prev_reg[gi];
        // A fresh edge beats the acknowledge clearing the same line.
        assign pending_next[gi] = rise[gi] | (pending[gi] & ~ack_this);
        // An edge coincident with its own acknowledge is a new request, not an
        // overrun. A set event beats clr_ovr for its bit.
        assign ovr_next[gi] = (rise[gi] & pending[gi] & ~ack_this)
                            | (ovr[gi] & ~clr_ovr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev_reg <= '0;
            pending      <= '0;
            ovr          <= '0;
            vec_valid    <= 1'b0;
            vec_id       <= '0;
            state_reg    <= ST_IDLE;
        end else begin
            irq_prev_reg <= irq_in;
            pending      <= pending_next;
            ovr          <= ovr_next;
            case (state_reg)
                ST_IDLE: begin
                    if (sel_any) begin
                        vec_id    <= sel_idx;
                        vec_valid <= 1'b1;
                        state_reg <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    // Returning to IDLE forces at least one cycle with
                    // vec_valid low before the next vector.
                    if (vec_ack) begin
                        vec_valid <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    vec_valid <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_dispatch12.sv
module tb_irq_dispatch12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:11] irq_in;
    logic [0:11] mask;
    logic        vec_ack;
    logic        clr_ovr;
    logic        vec_valid;
    logic [3:0]  vec_id;
    logic [0:11] pending;
    logic [0:11] ovr;

    irq_dispatch12 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_in),
        .mask      (mask),
        .vec_ack   (vec_ack),
        .clr_ovr   (clr_ovr),
        .vec_valid (vec_valid),
        .vec_id    (vec_id),
        .pending   (pending),
        .ovr       (ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  id;
        logic [0:11] p;
        logic [0:11] o;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    bit   done   = 0;

    // Reference model: behavioural view of the dispatcher's rules.
    bit m_prev [12];
    bit m_pend [12];
    bit m_ovr  [12];
    bit m_valid;
    int m_id;

    function automatic logic [0:11] one_hot(input int k);
        logic [0:11] r;
        r = '0;
        r[k] = 1'b1;
        return r;
    endfunction

    task automatic model_push();
        exp_t e;
        e.v  = m_valid;
        e.id = 4'(m_id);
        for (int k = 0; k < 12; k++) begin
            e.p[k] = m_pend[k];
            e.o[k] = m_ovr[k];
        end
        exp_q.push_back(e);
    endtask

    // Predict the state after the coming clock edge from the inputs now driven.
    task automatic model_step();
        bit ack, rise, kill;
        int sel;
        bit np [12];
        bit no [12];
        if (!rst_n) begin
            for (int k = 0; k < 12; k++) begin
                m_prev[k] = 0; m_pend[k] = 0; m_ovr[k] = 0;
            end
            m_valid = 0;
            m_id    = 0;
            model_push();
            return;
        end
        ack = m_valid && vec_ack;
        sel = -1;
        for (int k = 0; k < 12; k++)
            if (sel < 0 && m_pend[k] && !mask[k]) sel = k;
        for (int k = 0; k < 12; k++) begin
            rise  = irq_in[k] && !m_prev[k];
            kill  = ack && (k == m_id);
            np[k] = rise ? 1'b1 : (kill ? 1'b0 : m_pend[k]);
            no[k] = (rise && m_pend[k] && !kill) ? 1'b1 : (clr_ovr ? 1'b0 : m_ovr[k]);
        end
        for (int k = 0; k < 12; k++) begin
            m_pend[k] = np[k];
            m_ovr[k]  = no[k];
            m_prev[k] = irq_in[k];
        end
        if (!m_valid) begin
            if (sel >= 0) begin
                m_valid = 1;
                m_id    = sel;
            end
        end else if (ack) begin
            m_valid = 0;
        end
        model_push();
    endtask

    // One clock cycle of stimulus; inputs change 3 time units after the edge.
    task automatic cyc(input logic [0:11] irq, input logic [0:11] msk,
                       input logic ack, input logic clr);
        @(posedge clk);
        #3;
        irq_in  = irq;
        mask    = msk;
        vec_ack = ack;
        clr_ovr = clr;
        model_step();
    endtask

    // Idle until the model presents a vector, then acknowledge it while
    // driving irq_ack on the request lines.
    task automatic ack_next(input logic [0:11] irq_wait, input logic [0:11] irq_ack,
                            input logic [0:11] msk);
        for (int i = 0; i < 20 && !m_valid; i++) cyc(irq_wait, msk, 1'b0, 1'b0);
        if (!m_valid) begin
            $display("FAIL ack_next_timeout: vec_valid=0 required=1");
            n_err++;
        end
        cyc(irq_ack, msk, 1'b1, 1'b0);
    endtask

    // Monitor: compare DUT state 1 time unit after each edge.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (vec_valid !== e.v || (e.v && vec_id !== e.id) || pending !== e.p || ovr !== e.o) begin
                    n_err++;
                    $display("FAIL state@%0t: valid=%b id=%0d pend=%b ovr=%b required valid=%b id=%0d pend=%b ovr=%b",
                             $time, vec_valid, vec_id, pending, ovr, e.v, e.id, e.p, e.o);
                end
            end
        end
    end

    logic [0:11] z;
    logic [0:11] mk;
    logic [0:11] r;

    initial begin
        z       = '0;
        irq_in  = '0;
        mask    = '0;
        vec_ack = 1'b0;
        clr_ovr = 1'b0;
        rst_n   = 1'b0;
        #1;
        n_vec++;
        if (vec_valid !== 1'b0 || vec_id !== 4'd0 || pending !== 12'd0 || ovr !== 12'd0) begin
            n_err++;
            $display("FAIL reset_state: valid=%b id=%0d pend=%b ovr=%b required all zero",
                     vec_valid, vec_id, pending, ovr);
        end
        cyc(z, z, 0, 0);
        cyc(z, z, 0, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        model_step();
        cyc(z, z, 0, 0);

        // Single pulse on line 5, acknowledged.
        cyc(one_hot(5), z, 0, 0);
        ack_next(z, z, z);
        cyc(z, z, 0, 0);

        // Lines 3 and 9 together: 3 first, then 9 after an idle cycle.
        cyc(one_hot(3) | one_hot(9), z, 0, 0);
        ack_next(z, z, z);
        ack_next(z, z, z);
        cyc(z, z, 0, 0);

        // Line 7 presented, line 1 arrives meanwhile: no preemption.
        cyc(one_hot(7), z, 0, 0);
        cyc(z, z, 0, 0);
        cyc(z, z, 0, 0);
        cyc(one_hot(1), z, 0, 0);
        cyc(one_hot(1), z, 0, 0);
        ack_next(z, z, z);
        ack_next(z, z, z);
        cyc(z, z, 0, 0);

        // Masked line 2 stays latched, then dispatches when unmasked.
        mk = one_hot(2);
        cyc(one_hot(2), mk, 0, 0);
        for (int i = 0; i < 4; i++) cyc(z, mk, 0, 0);
        cyc(z, z, 0, 0);
        ack_next(z, z, z);
        cyc(z, z, 0, 0);

        // Overrun on line 4, clear, then edge coincident with its ack.
        mk = one_hot(4);
        cyc(one_hot(4), mk, 0, 0);
        cyc(z, mk, 0, 0);
        cyc(one_hot(4), mk, 0, 0);
        cyc(z, mk, 0, 1);
        cyc(z, z, 0, 0);
        ack_next(z, one_hot(4), z);
        cyc(z, z, 0, 0);
        ack_next(z, z, z);
        cyc(z, z, 0, 0);

        // Overrun set and clr_ovr in the same cycle: set wins.
        cyc(one_hot(6), one_hot(6), 0, 0);
        cyc(z, one_hot(6), 0, 0);
        cyc(one_hot(6), one_hot(6), 0, 1);
        cyc(z, z, 0, 1);
        ack_next(z, z, z);

        // Reset while presenting; line 7 held high through reset.
        cyc(one_hot(7), z, 0, 0);
        for (int i = 0; i < 20 && !m_valid; i++) cyc(one_hot(7), z, 0, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_vec++;
        if (vec_valid !== 1'b0 || vec_id !== 4'd0 || pending !== 12'd0 || ovr !== 12'd0) begin
            n_err++;
            $display("FAIL async_reset: valid=%b id=%0d pend=%b ovr=%b required all zero",
                     vec_valid, vec_id, pending, ovr);
        end
        model_step();
        cyc(one_hot(7), z, 0, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        model_step();
        ack_next(one_hot(7), one_hot(7), z);
        cyc(z, z, 0, 0);

        // Randomized traffic.
        r  = '0;
        mk = '0;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 12; k++)
                if ($urandom_range(0, 7) == 0) r[k] = ~r[k];
            if ((c % 16) == 0)
                for (int k = 0; k < 12; k++) mk[k] = ($urandom_range(0, 4) == 0);
            cyc(r, mk, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0));
        end
        cyc(z, z, 0, 0);
        cyc(z, z, 0, 0);

        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: left=%0d required=0", exp_q.size());
        end
        done = 1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
